// File: rtl/s2p_conv_1x8.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : s2p_conv_1x8                                                   |
// | Function : MSB-first serial-to-byte assembler with frame tagging and a    |
// |            first-word-fall-through output FIFO (valid/ready downstream).  |
// | Option   : S2P_ERR_CNT_EN adds a saturating 16-bit alignment-error count. |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module s2p_conv_1x8 #(
  parameter int FRAME_BYTES = 188,
  parameter int BUF_DEPTH   = 4
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        idat,
  input  logic        ival,
  input  logic        isop,
  output logic        oreq,
  output logic [7:0]  odat,
  output logic        oval,
  output logic        osop,
  output logic        oeop,
  input  logic        ireq,
  output logic        oerr
`ifdef S2P_ERR_CNT_EN
  ,
  output logic [15:0] oerr_cnt
`endif
);

  localparam int c_bcw = $clog2(FRAME_BYTES);
  localparam int c_aw  = $clog2(BUF_DEPTH);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam logic [c_bcw-1:0] c_last_byte = c_bcw'(FRAME_BYTES - 1);
  localparam logic [c_bcw-1:0] c_byte_one  = c_bcw'(1);
  localparam logic [c_aw:0]    c_cnt_one   = (c_aw + 1)'(1);
  localparam logic [c_aw:0]    c_cnt_full  = (c_aw + 1)'(BUF_DEPTH);
  localparam logic [c_aw-1:0]  c_ptr_one   = c_aw'(1);

  logic [0:0]       r_state;
  logic [2:0]       r_bit_cnt;
  logic [c_bcw-1:0] r_byte_cnt;
  logic [6:0]       r_shift;
  logic             r_sop_flag;
  logic             r_oerr;

  // Entry layout: {sop, eop, byte}
  logic [9:0]       r_mem [BUF_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic       w_run;
  logic       w_full;
  logic       w_accept;
  logic       w_align_err;
  logic       w_eop;
  logic       w_push;
  logic       w_pop;
  logic [9:0] w_head;

  assign w_run       = (r_state == c_st_run);
  assign w_full      = (r_count == c_cnt_full);
  // Only the byte-completing bit can stall; ireq is deliberately kept out of this path.
  assign oreq        = ~(w_run && (r_bit_cnt == 3'd7) && w_full);
  assign w_accept    = ival && oreq;
  assign w_align_err = w_accept && w_run && isop &&
                       ((r_bit_cnt != 3'd0) || (r_byte_cnt != '0));
  assign w_eop       = (r_byte_cnt == c_last_byte);
  assign w_push      = w_accept && w_run && !w_align_err && (r_bit_cnt == 3'd7);
  assign w_pop       = oval && ireq;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_state    <= c_st_idle;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_sop_flag <= 1'b0;
      r_oerr     <= 1'b0;
    end else begin
      r_oerr <= w_align_err;
      if (w_accept) begin
        r_shift <= {r_shift[5:0], idat};
        if (!w_run) begin
          if (isop) begin
            r_state    <= c_st_run;
            r_bit_cnt  <= 3'd1;
            r_byte_cnt <= '0;
            r_sop_flag <= 1'b1;
          end
        end else if (w_align_err) begin
          // Resynchronise on the new marker; the partial byte is abandoned.
          r_bit_cnt  <= 3'd1;
          r_byte_cnt <= '0;
          r_sop_flag <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_sop_flag <= 1'b0;
            if (w_eop) begin
              r_byte_cnt <= '0;
              r_state    <= c_st_idle;
            end else begin
              r_byte_cnt <= r_byte_cnt + c_byte_one;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_sop_flag, w_eop, r_shift, idat};
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // Head fields are masked while empty so stale storage never leaks out.
  assign w_head = r_mem[r_rd_ptr];
  assign oval   = (r_count != '0);
  assign odat   = oval ? w_head[7:0] : 8'h00;
  assign osop   = oval & w_head[9];
  assign oeop   = oval & w_head[8];
  assign oerr   = r_oerr;

`ifdef S2P_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_err_cnt <= 16'h0000;
    end else if (r_oerr && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign oerr_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s2p_conv_1x8.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_s2p_conv_1x8                                                |
// | Function : Directed self-checking bench for s2p_conv_1x8 (4-byte frames). |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_s2p_conv_1x8;

  localparam int FB = 4;
  localparam int BD = 4;

  logic       iclk = 1'b0;
  logic       irst = 1'b0;
  logic       idat = 1'b0;
  logic       ival = 1'b0;
  logic       isop = 1'b0;
  logic       ireq = 1'b0;
  logic       oreq;
  logic [7:0] odat;
  logic       oval;
  logic       osop;
  logic       oeop;
  logic       oerr;
`ifdef S2P_ERR_CNT_EN
  logic [15:0] oerr_cnt;
`endif

  s2p_conv_1x8 #(.FRAME_BYTES(FB), .BUF_DEPTH(BD)) dut (
    .iclk(iclk), .irst(irst), .idat(idat), .ival(ival), .isop(isop),
    .oreq(oreq), .odat(odat), .oval(oval), .osop(osop), .oeop(oeop),
    .ireq(ireq), .oerr(oerr)
`ifdef S2P_ERR_CNT_EN
    , .oerr_cnt(oerr_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_sop = 0;
  int         n_eop = 0;
  int         n_oerr = 0;
  bit         rnd_mode = 1'b0;
  logic [9:0] q_got[$];
  logic [9:0] q_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every handshake-completed byte as {sop, eop, data}.
  always @(negedge iclk) begin
    if (irst) begin
      if (oval && ireq) begin
        q_got.push_back({osop, oeop, odat});
        if (osop) n_sop++;
        if (oeop) n_eop++;
      end
      if (oerr) n_oerr++;
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Called at posedge+1; returns at posedge+1 after the bit was accepted.
  task automatic send_bit(input logic d, input logic s);
    int t;
    t = 0;
    if (rnd_mode) begin
      while ($urandom_range(0, 99) < 30) begin
        ireq = ($urandom_range(0, 99) < 60);
        tick();
      end
      ireq = ($urandom_range(0, 99) < 60);
    end
    idat = d;
    isop = s;
    ival = 1'b1;
    while (!oreq && t < 50) begin
      tick();
      if (rnd_mode) ireq = ($urandom_range(0, 99) < 60);
      t++;
    end
    if (t >= 50) chk("oreq_timeout", 32'(t), 32'd0);
    tick();
    ival = 1'b0;
    isop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first);
    for (int i = 7; i >= 0; i--) send_bit(b[i], first && (i == 7));
  endtask

  task automatic exp_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    q_exp.push_back({2'b10, b0});
    q_exp.push_back({2'b00, b1});
    q_exp.push_back({2'b00, b2});
    q_exp.push_back({2'b01, b3});
  endtask

  task automatic send_ref_frame();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
  endtask

  task automatic cmp_queue(input string tag);
    chk({tag, "_len"}, 32'(q_got.size()), 32'(q_exp.size()));
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++)
      chk(tag, 32'(q_got[i]), 32'(q_exp[i]));
    q_got.delete();
    q_exp.delete();
  endtask

  logic [7:0] ref_bytes [4];
  logic [7:0] rb;
  logic [7:0] tb_byte;

  initial begin
    ref_bytes[0] = 8'hA5;
    ref_bytes[1] = 8'h3C;
    ref_bytes[2] = 8'hFF;
    ref_bytes[3] = 8'h01;

    // Reset state
    #2;
    chk("rst_oreq", 32'(oreq), 32'd1);
    chk("rst_oval", 32'(oval), 32'd0);
    chk("rst_osop", 32'(osop), 32'd0);
    chk("rst_oeop", 32'(oeop), 32'd0);
    chk("rst_odat", 32'(odat), 32'h00);
    chk("rst_oerr", 32'(oerr), 32'd0);
    idle(2);
    irst = 1'b1;
    idle(1);

    // Test 1: reference frame, each byte visible one clock after its 8th bit
    ireq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_byte(ref_bytes[k], k == 0);
      chk("t1_oval", 32'(oval), 32'd1);
      chk("t1_odat", 32'(odat), 32'(ref_bytes[k]));
      chk("t1_osop", 32'(osop), 32'(k == 0));
      chk("t1_oeop", 32'(oeop), 32'(k == 3));
    end
    idle(4);
    exp_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    cmp_queue("t1_stream");

    // Test 2: unframed bits are discarded
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    idle(3);
    chk("t2_no_out", 32'(q_got.size()), 32'd0);
    send_ref_frame();
    idle(4);
    exp_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    cmp_queue("t2_stream");
    chk("t2_no_oerr", 32'(n_oerr), 32'd0);

    // Test 3: short frame interrupted by a new isop
    send_byte(8'hA5, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      rb = 8'hA5;
      send_bit(rb[i], i == 7);
      if (i == 7) chk("t3_oerr_hi", 32'(oerr), 32'd1);
      if (i == 6) chk("t3_oerr_lo", 32'(oerr), 32'd0);
    end
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
    idle(4);
    q_exp.push_back({2'b10, 8'hA5});
    exp_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    cmp_queue("t3_stream");
    chk("t3_oerr_cnt", 32'(n_oerr), 32'd1);
`ifdef S2P_ERR_CNT_EN
    chk("t3_err_cnt", 32'(oerr_cnt), 32'd1);
`endif

    // Test 4: backpressure with a full FIFO
    ireq = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("t4_oreq_after4", 32'(oreq), 32'd1);
    tb_byte = 8'h55;
    for (int i = 7; i >= 1; i--) send_bit(tb_byte[i], i == 7);
    chk("t4_stall", 32'(oreq), 32'd0);
    idle(2);
    chk("t4_stall_hold", 32'(oreq), 32'd0);
    chk("t4_head_hold", 32'(odat), 32'h11);
    chk("t4_head_sop", 32'(osop), 32'd1);
    idat = tb_byte[0];
    ival = 1'b1;
    ireq = 1'b1;
    tick();
    chk("t4_oreq_back", 32'(oreq), 32'd1);
    chk("t4_head_next", 32'(odat), 32'h22);
    tick();
    ival = 1'b0;
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    idle(8);
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44);
    exp_frame(8'h55, 8'h66, 8'h77, 8'h88);
    cmp_queue("t4_stream");

    // Test 5: random gaps and random downstream ready over 100 frames
    n_sop = 0;
    n_eop = 0;
    rnd_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int b = 0; b < FB; b++) begin
        tb_byte = 8'($urandom_range(0, 255));
        q_exp.push_back({(b == 0), (b == FB - 1), tb_byte});
        send_byte(tb_byte, b == 0);
      end
    end
    rnd_mode = 1'b0;
    ireq = 1'b1;
    idle(10);
    cmp_queue("t5_stream");
    chk("t5_sop_cnt", 32'(n_sop), 32'd100);
    chk("t5_eop_cnt", 32'(n_eop), 32'd100);

    // Test 6: reset mid-byte with two bytes buffered
    ireq = 1'b0;
    send_byte(8'hC3, 1'b1);
    send_byte(8'h7E, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t6_pre_oval", 32'(oval), 32'd1);
    irst = 1'b0;
    #1;
    chk("t6_rst_oval", 32'(oval), 32'd0);
    chk("t6_rst_osop", 32'(osop), 32'd0);
    chk("t6_rst_oeop", 32'(oeop), 32'd0);
    chk("t6_rst_oerr", 32'(oerr), 32'd0);
    chk("t6_rst_oreq", 32'(oreq), 32'd1);
`ifdef S2P_ERR_CNT_EN
    chk("t6_err_cnt", 32'(oerr_cnt), 32'd0);
`endif
    tick();
    irst = 1'b1;
    ireq = 1'b1;
    tick();
    send_ref_frame();
    idle(4);
    exp_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    cmp_queue("t6_stream");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
